// File: rtl/instr_encoder.sv
// instr_encoder: encodes ALU requests into R-type words, buffered in a FIFO and streamed out.
// Define INSTR_ENC_FRAME_EN to wrap each program in FIRST/HALT words (honours req_last).
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic        req_last,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        busy,
    output logic        err_op
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] FIRST_WORD = 32'h0000_0037;
    localparam logic [31:0] HALT_WORD  = 32'h0000_003F;

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, HALT} state_t;

    state_t        state;
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, push, pop, lock, head_last, op_ok;
    logic [5:0]    funct;
    logic [31:0]   word, head;

    always_comb begin
        funct = req_op == 3'b000 ? 6'b100000 :
                req_op == 3'b001 ? 6'b100010 :
                req_op == 3'b010 ? 6'b100100 :
                req_op == 3'b011 ? 6'b100101 : 6'b101010;
        op_ok = !req_op[2] || req_op == 3'b111;
        word  = op_ok ? {6'b000000, req_rs, req_rt, req_rd, 5'b00000, funct} : 32'h0;
    end

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign push  = req_valid && req_ready;
    assign pop   = state == STREAM && !empty && instr_ready;
    assign {head, head_last} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {word, req_last};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_op <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
            err_op <= push && !op_ok;
        end
    end

`ifdef INSTR_ENC_FRAME_EN
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // lock keeps the next program out until the current one's HALT is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock <= 1'b0;
        else if (push && req_last) lock <= 1'b1;
        else if (state == HALT && instr_ready) lock <= 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = (push || !empty) ? FIRST : IDLE;
            FIRST:  state_nxt = instr_ready ? STREAM : FIRST;
            STREAM: state_nxt = (pop && head_last) ? HALT : STREAM;
            HALT:   state_nxt = instr_ready ? IDLE : HALT;
        endcase
    end

    assign busy = state != IDLE || !empty;
`else
    logic unused_last;

    assign state       = STREAM;
    assign lock        = 1'b0;
    assign busy        = !empty;
    assign unused_last = head_last ^ req_last;
`endif

    always_comb begin
        instr_valid = state == FIRST || state == HALT || (state == STREAM && !empty);
        instr       = state == FIRST ? FIRST_WORD :
                      state == HALT  ? HALT_WORD  :
                      instr_valid    ? head       : 32'h0;
        req_ready   = !full && !lock;
    end
endmodule
